// File: rtl/lmem_copy_dma_pkg.sv
// Shared types for the local-memory copy engine: lane-field sizing, tag layout and FSM states.
package lmem_copy_dma_pkg;

  // Lane field is at least one bit wide so a single-lane engine still has an index to check.
  function automatic int lmem_lane_bits(input int num_lanes);
    return (num_lanes <= 2) ? 1 : $clog2(num_lanes);
  endfunction

  localparam int LMEM_DEF_TAG_WIDTH = 16;
  localparam int LMEM_DEF_LANE_BITS = 2;

  typedef struct packed {
    logic [LMEM_DEF_TAG_WIDTH-LMEM_DEF_LANE_BITS-2:0] pad;
    logic                                             parity;
    logic [LMEM_DEF_LANE_BITS-1:0]                    lane;
  } lmem_tag_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_DONE     = 3'd4
  } lmem_dma_state_t;

endpackage

// File: rtl/lmem_copy_dma_lane.sv
// One request lane: pending flags, read-data buffer and the registered request it presents.
module lmem_copy_dma_lane #(
  parameter int ADDR_WIDTH = 14,
  parameter int WORD_SIZE  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_rd,
  input  logic                    load_wr,
  input  logic                    load_mask,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic                    req_ready,
  input  logic                    rsp_we,
  input  logic [WORD_SIZE*8-1:0]  rsp_data,
  output logic                    req_valid,
  output logic                    req_rw,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [WORD_SIZE-1:0]    req_byteen,
  output logic [WORD_SIZE*8-1:0]  req_data,
  output logic                    resp_pend
);

  logic                   req_pend_q, req_pend_d;
  logic                   resp_pend_q, resp_pend_d;
  logic                   rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_SIZE*8-1:0] buf_q, buf_d;

  always_comb begin
    req_pend_d  = req_pend_q;
    resp_pend_d = resp_pend_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    if (req_pend_q && req_ready) req_pend_d = 1'b0;
    if (rsp_we) begin
      resp_pend_d = 1'b0;
      buf_d       = rsp_data;
    end
    if (load_rd || load_wr) begin
      req_pend_d = load_mask;
      rw_d       = load_wr;
      addr_d     = load_addr;
    end
    if (load_rd) resp_pend_d = load_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_pend_q  <= 1'b0;
      resp_pend_q <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      buf_q       <= '0;
    end else begin
      req_pend_q  <= req_pend_d;
      resp_pend_q <= resp_pend_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
    end
  end

  assign req_valid  = req_pend_q;
  assign req_rw     = rw_q;
  assign req_addr   = addr_q;
  assign req_byteen = {WORD_SIZE{req_pend_q}};
  assign req_data   = (req_pend_q && rw_q) ? buf_q : '0;
  assign resp_pend  = resp_pend_q;

endmodule

// File: rtl/lmem_copy_dma.sv
// Local-memory block copy engine: batched reads across lanes, then batched writes, until count words move.
//   state       | meaning
//   ST_IDLE     | waiting for start; responses dropped
//   ST_RD_ISSUE | read requests outstanding on masked lanes
//   ST_RD_WAIT  | all reads accepted, collecting responses
//   ST_WR_ISSUE | writing the buffered batch to the destination
//   ST_DONE     | one-cycle completion pulse
module lmem_copy_dma
  import lmem_copy_dma_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             src_addr,
  input  logic [ADDR_WIDTH-1:0]             dst_addr,
  input  logic [CNT_WIDTH-1:0]              count,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_LANES-1:0]              mem_req_valid,
  output logic [NUM_LANES-1:0]              mem_req_rw,
  output logic [NUM_LANES*ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [NUM_LANES*WORD_SIZE-1:0]    mem_req_byteen,
  output logic [NUM_LANES*WORD_SIZE*8-1:0]  mem_req_data,
  output logic [NUM_LANES*TAG_WIDTH-1:0]    mem_req_tag,
  input  logic [NUM_LANES-1:0]              mem_req_ready,
  input  logic [NUM_LANES-1:0]              mem_rsp_valid,
  input  logic [NUM_LANES*WORD_SIZE*8-1:0]  mem_rsp_data,
  input  logic [NUM_LANES*TAG_WIDTH-1:0]    mem_rsp_tag,
  output logic [NUM_LANES-1:0]              mem_rsp_ready
);

  localparam int LANE_BITS = lmem_lane_bits(NUM_LANES);
  localparam int DW        = WORD_SIZE * 8;
  localparam int BW        = CNT_WIDTH + 1;

  lmem_dma_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d, dst_q, dst_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]           base_q, base_d;
  logic                    parity_q, parity_d;
  logic [NUM_LANES-1:0]    mask_q, mask_d;
  logic                    busy_q, done_q;

  logic                          load_rd, load_wr;
  logic [NUM_LANES-1:0]          req_left, resp_left, resp_pend, rsp_we, load_mask;
  logic [NUM_LANES*ADDR_WIDTH-1:0] load_addr;
  logic [NUM_LANES*DW-1:0]       rsp_wdata;
  logic                          rd_phase;

  assign rd_phase = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);

  // A response is routed by its tag, not by the lane it arrives on; stale parity is dropped.
  always_comb begin
    rsp_we    = '0;
    rsp_wdata = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        if (rd_phase && mem_rsp_valid[j] &&
            mem_rsp_tag[j*TAG_WIDTH +: TAG_WIDTH] ==
              TAG_WIDTH'({parity_q, LANE_BITS'(i)})) begin
          rsp_we[i]              = 1'b1;
          rsp_wdata[i*DW +: DW]  = mem_rsp_data[j*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    parity_d  = parity_q;
    mask_d    = mask_q;
    load_rd   = 1'b0;
    load_wr   = 1'b0;
    load_addr = '0;
    req_left  = mem_req_valid & ~mem_req_ready;
    resp_left = resp_pend & ~rsp_we;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = count;
          base_d = '0;
          if (count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_ISSUE;
            load_rd = 1'b1;
          end
        end
      end
      ST_RD_ISSUE: begin
        if (req_left == '0) begin
          if (resp_left == '0) begin
            state_d = ST_WR_ISSUE;
            load_wr = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (resp_left == '0) begin
          state_d = ST_WR_ISSUE;
          load_wr = 1'b1;
        end
      end
      ST_WR_ISSUE: begin
        if (req_left == '0) begin
          base_d   = base_q + BW'(NUM_LANES);
          parity_d = ~parity_q;
          if (base_d >= {1'b0, cnt_q}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_ISSUE;
            load_rd = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (load_rd) begin
      for (int i = 0; i < NUM_LANES; i++)
        mask_d[i] = (32'(base_d) + 32'(i)) < 32'(cnt_d);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      load_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = load_rd ?
        ADDR_WIDTH'(32'(src_d) + 32'(base_d) + 32'(i)) :
        ADDR_WIDTH'(32'(dst_q) + 32'(base_q) + 32'(i));
    end
  end

  assign load_mask = load_rd ? mask_d : mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      parity_q <= 1'b0;
      mask_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      parity_q <= parity_d;
      mask_q   <= mask_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lmem_copy_dma_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_SIZE  (WORD_SIZE)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .load_rd    (load_rd),
      .load_wr    (load_wr),
      .load_mask  (load_mask[i]),
      .load_addr  (load_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .req_ready  (mem_req_ready[i]),
      .rsp_we     (rsp_we[i]),
      .rsp_data   (rsp_wdata[i*DW +: DW]),
      .req_valid  (mem_req_valid[i]),
      .req_rw     (mem_req_rw[i]),
      .req_addr   (mem_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .req_byteen (mem_req_byteen[i*WORD_SIZE +: WORD_SIZE]),
      .req_data   (mem_req_data[i*DW +: DW]),
      .resp_pend  (resp_pend[i])
    );

    // Tag is a function of lane and current batch parity, so it holds steady while valid is up.
    assign mem_req_tag[i*TAG_WIDTH +: TAG_WIDTH] = TAG_WIDTH'({parity_q, LANE_BITS'(i)});
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_rsp_ready = '1;

endmodule

// File: tb/tb_lmem_copy_dma.sv
// Directed bench for lmem_copy_dma with a behavioural local-memory responder.
module tb_lmem_copy_dma;
  import lmem_copy_dma_pkg::*;

  localparam int NL = 4;
  localparam int AW = 14;
  localparam int WS = 4;
  localparam int TW = 16;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     src_addr = '0;
  logic [AW-1:0]     dst_addr = '0;
  logic [CW-1:0]     count = '0;
  logic              busy, done;
  logic [NL-1:0]     mem_req_valid, mem_req_rw;
  logic [NL*AW-1:0]  mem_req_addr;
  logic [NL*WS-1:0]  mem_req_byteen;
  logic [NL*32-1:0]  mem_req_data;
  logic [NL*TW-1:0]  mem_req_tag;
  logic [NL-1:0]     mem_req_ready = '1;
  logic [NL-1:0]     mem_rsp_valid = '0;
  logic [NL*32-1:0]  mem_rsp_data = '0;
  logic [NL*TW-1:0]  mem_rsp_tag = '0;
  logic [NL-1:0]     mem_rsp_ready;

  always #5 clk = ~clk;

  lmem_copy_dma #(
    .NUM_LANES(NL), .ADDR_WIDTH(AW), .WORD_SIZE(WS), .TAG_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .busy(busy), .done(done),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready)
  );

  typedef struct {
    int          due;
    int          lane;
    logic [15:0] tag;
    logic [31:0] data;
  } rsp_t;

  rsp_t        pend[$];
  rsp_t        held[$];
  logic [31:0] mem [16384];
  int          ord [4] = '{3, 1, 0, 2};
  int cyc, rd_total, rsp_total, wr_total, act_cnt, done_cnt, viol_cnt, bad_be;
  int lane_acc [NL];
  int rsp_mode = 0;      // 0: 1-cycle, 1: out-of-order + random ready, 2: hold reads
  int release_req = 0;
  int release_ack;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder: observes handshakes mid-cycle, drives ready/responses just after the edge.
  initial begin
    rsp_t e;
    int a, t, i;
    lmem_tag_t tg;
    for (int k = 0; k < 16384; k++) mem[k] = 32'(k);
    cyc = 0; rd_total = 0; rsp_total = 0; wr_total = 0; act_cnt = 0;
    done_cnt = 0; viol_cnt = 0; bad_be = 0; release_ack = 0;
    for (int l = 0; l < NL; l++) lane_acc[l] = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (mem_req_valid != '0) act_cnt++;
      for (int l = 0; l < NL; l++) begin
        if (mem_req_valid[l] && mem_req_ready[l]) begin
          lane_acc[l]++;
          a = int'(mem_req_addr[l*AW +: AW]);
          if (mem_req_rw[l]) begin
            mem[a] = mem_req_data[l*32 +: 32];
            wr_total++;
            if (mem_req_byteen[l*WS +: WS] != 4'hf) bad_be++;
            if (rsp_mode == 1 && rd_total != rsp_total) viol_cnt++;
          end else begin
            rd_total++;
            e.tag = mem_req_tag[l*TW +: TW];
            e.data = mem[a];
            e.lane = l;
            e.due = cyc + 1;
            if (rsp_mode == 0) pend.push_back(e);
            else held.push_back(e);
          end
        end
      end
      if (rsp_mode == 1 && held.size() == 4) begin
        t = cyc + 1;
        for (int k = 0; k < 4; k++) begin
          for (int h = 0; h < held.size(); h++) begin
            tg = lmem_tag_t'(held[h].tag);
            if (int'(tg.lane) == ord[k]) e = held[h];
          end
          e.due = t;
          e.lane = 3 - ord[k];
          pend.push_back(e);
          t += int'($urandom_range(0, 5));
        end
        held.delete();
      end
      @(posedge clk);
      #1;
      cyc++;
      if (release_ack != release_req) begin
        for (int h = 0; h < held.size(); h++) begin
          e = held[h];
          e.due = cyc;
          pend.push_back(e);
        end
        held.delete();
        release_ack = release_req;
      end
      mem_req_ready = (rsp_mode == 1) ? 4'($urandom_range(0, 15)) : '1;
      mem_rsp_valid = '0;
      mem_rsp_tag = '0;
      mem_rsp_data = '0;
      i = 0;
      while (i < pend.size()) begin
        if (pend[i].due <= cyc && !mem_rsp_valid[pend[i].lane]) begin
          mem_rsp_valid[pend[i].lane] = 1'b1;
          mem_rsp_tag[pend[i].lane*TW +: TW] = pend[i].tag;
          mem_rsp_data[pend[i].lane*32 +: 32] = pend[i].data;
          rsp_total++;
          pend.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [CW-1:0] c);
    src_addr = s;
    dst_addr = d;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int s_wr, s_done, s_act, s_rd, s_l2, s_l3;
    int n;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(mem_req_valid), 0);
    chk("rst_rsp_ready", 32'(mem_rsp_ready), 32'hf);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Two full batches, 1-cycle memory.
    s_wr = wr_total; s_done = done_cnt;
    start_copy(14'h10, 14'h100, 16'd8);
    wait_done("t1_done");
    settle();
    for (int k = 0; k < 8; k++) chk("t1_mem", mem[16'h100 + k], 32'h10 + 32'(k));
    chk("t1_writes", 32'(wr_total - s_wr), 8);
    chk("t1_done_pulses", 32'(done_cnt - s_done), 1);
    chk("t1_busy_after", 32'(busy), 0);

    // Partial final batch.
    s_wr = wr_total; s_l2 = lane_acc[2]; s_l3 = lane_acc[3];
    start_copy(14'h10, 14'h180, 16'd6);
    wait_done("t2_done");
    settle();
    for (int k = 0; k < 6; k++) chk("t2_mem", mem[16'h180 + k], 32'h10 + 32'(k));
    chk("t2_untouched", mem[16'h186], 32'h186);
    chk("t2_writes", 32'(wr_total - s_wr), 6);
    chk("t2_lane2_xfers", 32'(lane_acc[2] - s_l2), 2);
    chk("t2_lane3_xfers", 32'(lane_acc[3] - s_l3), 2);

    // Zero-length copy.
    s_act = act_cnt;
    start_copy(14'h10, 14'h500, 16'd0);
    chk("t3_done_next", 32'(done), 1);
    @(posedge clk);
    #1;
    chk("t3_done_single", 32'(done), 0);
    settle();
    chk("t3_busy", 32'(busy), 0);
    chk("t3_no_valid", 32'(act_cnt - s_act), 0);

    // Out-of-order responses across lanes with random ready.
    rsp_mode = 1;
    start_copy(14'h60, 14'h400, 16'd8);
    wait_done("t4_done");
    rsp_mode = 0;
    settle();
    for (int k = 0; k < 8; k++) chk("t4_mem", mem[16'h400 + k], 32'h60 + 32'(k));
    chk("t4_early_writes", 32'(viol_cnt), 0);

    // Reset while waiting on read responses, then late responses arrive in IDLE.
    rsp_mode = 2;
    s_rd = rd_total;
    start_copy(14'h30, 14'h200, 16'd8);
    n = 0;
    while (rd_total - s_rd < 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("t5_reads_issued", 32'(rd_total - s_rd), 4);
    chk("t5_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_busy_rst", 32'(busy), 0);
    chk("t5_valid_rst", 32'(mem_req_valid), 0);
    rsp_mode = 0;
    release_req++;
    s_act = act_cnt; s_done = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_stale_no_valid", 32'(act_cnt - s_act), 0);
    chk("t5_stale_no_done", 32'(done_cnt - s_done), 0);
    chk("t5_stale_busy", 32'(busy), 0);
    chk("t5_no_write", mem[16'h200], 32'h200);
    start_copy(14'h20, 14'h40, 16'd4);
    wait_done("t5_new_done");
    settle();
    for (int k = 0; k < 4; k++) chk("t5_mem", mem[16'h40 + k], 32'h20 + 32'(k));

    // start during WR_ISSUE is ignored.
    s_wr = wr_total; s_done = done_cnt;
    start_copy(14'h10, 14'h300, 16'd8);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (mem_req_valid != '0 && mem_req_rw[0]) seen = 1'b1;
    end
    src_addr = 14'h50;
    dst_addr = 14'h380;
    count = 16'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t6_in_write", 32'(seen), 1);
    wait_done("t6_done");
    settle();
    for (int k = 0; k < 8; k++) chk("t6_mem", mem[16'h300 + k], 32'h10 + 32'(k));
    chk("t6_intruder_dst", mem[16'h380], 32'h380);
    chk("t6_writes", 32'(wr_total - s_wr), 8);
    chk("t6_done_pulses", 32'(done_cnt - s_done), 1);
    chk("byteen_all", 32'(bad_be), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
